can_bit_destuffer: RTL
======================

// Module: can_bit_destuffer
// PURPOSE
//  Parametrised CAN bit destuffer between bit-timing sampler and can_rx frame decoder.
//  Tracks runs of equal sampled bits over the stuffed region, removes each stuff bit,
//  forwards only data bits with a running bit index, and flags stuff-rule violations.
//  Replaces the fixed-5, counter-pair destuff logic with one run tracker, checking and error path.
// PARAMETERS
//  STUFF_LEN  5  equal-bit run length that forces a stuff bit (legal range 2..15)
//  IDX_W      7  width of o_Bit_Index (default covers 127 bits; widen for FD)
// PORTS
//  i_Clock        in  1      single clock, all logic on posedge
//  i_Reset        in  1      synchronous, active-high reset
//  i_Frame_Start  in  1      pulse: clear run/index/error state for a new frame
//  i_Stuff_En     in  1      high while the bit is inside the stuffed region (SOF..CRC)
//  i_Bit_Valid    in  1      one-cycle strobe per sampled bus bit
//  i_Bit          in  1      sampled bus bit, qualified by i_Bit_Valid
//  o_Bit_Valid    out 1      one-cycle strobe per forwarded (non-stuff) bit
//  o_Bit          out 1      forwarded data bit
//  o_Bit_Index    out IDX_W  index of the o_Bit just forwarded (0 = first bit of frame)
//  o_Stuff_Bit    out 1      one-cycle pulse when a stuff bit is removed
//  o_Stuff_Error  out 1      sticky stuff-rule violation flag
//  o_Stuff_Count  out 3      removed-stuff-bit count mod 8 (only with CAN_STUFF_CNT_EN)
// BEHAVIOUR
//  - Reset: all outputs 0; state COUNT; run_cnt=0; last_bit=1 (recessive); index=0.
//  - Latency: all outputs registered; input bit at edge N appears at edge N+1.
//  - States: COUNT, EXPECT_STUFF, ERROR.
//  - COUNT, valid bit, i_Stuff_En=1: if run_cnt==0 or bit!=last_bit then run_cnt=1, else
//    run_cnt+1; last_bit=bit; forward bit. If new run_cnt==STUFF_LEN -> EXPECT_STUFF.
//  - EXPECT_STUFF, valid bit, i_Stuff_En=1: bit!=last_bit -> drop it, pulse o_Stuff_Bit,
//    run_cnt=1, last_bit=bit (stuff bit opens next run), -> COUNT.
//    bit==last_bit -> o_Stuff_Error=1, bit not forwarded, -> ERROR.
//  - i_Stuff_En=0 with a valid bit (any non-ERROR state): bit forwarded unchecked,
//    run_cnt=0, -> COUNT (no stuff bit after the CRC field).
//  - ERROR: no forwarding, no pulses, o_Stuff_Error stays 1 until i_Frame_Start or i_Reset.
//  - o_Bit_Index: 0 for the first forwarded bit after i_Frame_Start, +1 per forwarded bit;
//    saturates at 2**IDX_W-1 (no wrap).
//  - i_Frame_Start with i_Bit_Valid in the same cycle: state cleared first, then that bit
//    is processed as bit 0 of the new frame.
//  - i_Frame_Start mid-run or in EXPECT_STUFF/ERROR: everything returns to reset values
//    except outputs of the current cycle; no error raised.
//  - i_Bit_Valid=0: state frozen; o_Bit_Valid/o_Stuff_Bit low.
//  - run_cnt width $clog2(STUFF_LEN+1); never exceeds STUFF_LEN.
// CONFIGURATION
//  CAN_STUFF_CNT_EN defined: o_Stuff_Count present; +1 mod 8 on each removed stuff bit,
//    cleared by i_Reset and i_Frame_Start; feeds the FD stuff-count field check.
//  CAN_STUFF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - can_pkg: state enum (COUNT/EXPECT_STUFF/ERROR), CAN_STUFF_LEN default = 5,
//    CAN_RECESSIVE = 1'b1 constant.
//  - Sub-module can_run_tracker: run_cnt/last_bit update, raises run_full at STUFF_LEN;
//    top level holds FSM, index counter, output registers, optional stuff counter.
// TESTING
//  - Stream 0,0,0,0,0,1,1 with stuff on -> 5 zeros forwarded idx 0..4, 1 dropped with
//    o_Stuff_Bit, next 1 forwarded idx 5.
//  - 0 x5 then 0 (stuff on) -> o_Stuff_Error=1 after 6th bit, no o_Bit_Valid until i_Frame_Start.
//  - 1 x5, stuff bit 0, then 0 x4 -> run restarts on stuff bit: 5th bit after stuff (4 data
//    0s + stuff) triggers EXPECT_STUFF; next 1 dropped.
//  - 0 x5 with i_Stuff_En dropping before 6th bit 0 -> 6th bit forwarded, no error.
//  - i_Frame_Start and i_Bit_Valid same cycle during ERROR -> error clears, bit gets idx 0.
//  - CAN_STUFF_CNT_EN, 9 stuff bits in one frame -> o_Stuff_Count=1; STUFF_LEN=3 run also checked.

Source files
------------

// File: rtl/can_bit_destuffer_pkg.sv
// can_pkg: shared FSM state type and CAN bit-level constants for the destuffer.
package can_pkg;
   typedef enum logic [1:0] {COUNT, EXPECT_STUFF, ERROR} state_t;
   localparam int CAN_STUFF_LEN = 5;
   localparam logic CAN_RECESSIVE = 1'b1;
endpackage

// File: rtl/can_bit_destuffer_if.sv
// can_bit_destuffer_if: sampler-side bit stream in, decoder-side destuffed stream out.
// o_Stuff_Count exists only when CAN_STUFF_CNT_EN is defined.
interface can_bit_destuffer_if #(parameter int IDX_W = 7);
   logic i_Frame_Start, i_Stuff_En, i_Bit_Valid, i_Bit;
   logic o_Bit_Valid, o_Bit, o_Stuff_Bit, o_Stuff_Error;
   logic [IDX_W-1:0] o_Bit_Index;
`ifdef CAN_STUFF_CNT_EN
   logic [2:0] o_Stuff_Count;
   modport master (output i_Frame_Start, i_Stuff_En, i_Bit_Valid, i_Bit,
                   input o_Bit_Valid, o_Bit, o_Bit_Index, o_Stuff_Bit, o_Stuff_Error, o_Stuff_Count);
   modport slave (input i_Frame_Start, i_Stuff_En, i_Bit_Valid, i_Bit,
                  output o_Bit_Valid, o_Bit, o_Bit_Index, o_Stuff_Bit, o_Stuff_Error, o_Stuff_Count);
`else
   modport master (output i_Frame_Start, i_Stuff_En, i_Bit_Valid, i_Bit,
                   input o_Bit_Valid, o_Bit, o_Bit_Index, o_Stuff_Bit, o_Stuff_Error);
   modport slave (input i_Frame_Start, i_Stuff_En, i_Bit_Valid, i_Bit,
                  output o_Bit_Valid, o_Bit, o_Bit_Index, o_Stuff_Bit, o_Stuff_Error);
`endif
endinterface

// File: rtl/can_bit_destuffer_run_tracker.sv
// can_run_tracker: equal-bit run length and last bit; i_Clear views state as freshly reset
// so a frame start and a bit in the same cycle act on the cleared run.
module can_run_tracker
   import can_pkg::*;
#(
   parameter int STUFF_LEN = CAN_STUFF_LEN
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Clear,
   input  logic i_Count,
   input  logic i_Restart,
   input  logic i_Zero,
   input  logic i_Bit,
   output logic o_Run_Full,
   output logic o_Differs
);
   localparam int RW = $clog2(STUFF_LEN + 1);
   logic [RW-1:0] run_cnt, cur_cnt, next_cnt;
   logic last_bit, cur_last;
   assign cur_cnt = i_Clear ? '0 : run_cnt;
   assign cur_last = i_Clear ? CAN_RECESSIVE : last_bit;
   assign o_Differs = i_Bit != cur_last;
   assign next_cnt = (cur_cnt == '0 || o_Differs) ? RW'(1) : cur_cnt + 1'b1;
   assign o_Run_Full = next_cnt == RW'(STUFF_LEN);
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         run_cnt <= '0;
         last_bit <= CAN_RECESSIVE;
      end else if (i_Count) begin
         run_cnt <= next_cnt;
         last_bit <= i_Bit;
      end else if (i_Restart) begin
         run_cnt <= RW'(1);
         last_bit <= i_Bit;
      end else if (i_Zero) begin
         run_cnt <= '0;
         last_bit <= cur_last;
      end else if (i_Clear) begin
         run_cnt <= '0;
         last_bit <= CAN_RECESSIVE;
      end
   end
endmodule

// File: rtl/can_bit_destuffer.sv
// can_bit_destuffer: removes CAN stuff bits, indexes forwarded bits, flags stuff violations.
// Optional removed-stuff-bit counter enabled by CAN_STUFF_CNT_EN.
module can_bit_destuffer
   import can_pkg::*;
#(
   parameter int STUFF_LEN = CAN_STUFF_LEN,
   parameter int IDX_W = 7
) (
   input logic i_Clock,
   input logic i_Reset,
   can_bit_destuffer_if.slave bus
);
   localparam logic [IDX_W-1:0] IDX_MAX = '1;
   state_t state_q, cur_state, state_d;
   logic [IDX_W-1:0] nidx_q, cur_nidx;
   logic fwd, stuff_pulse, viol, do_count, do_restart, do_zero, run_full, differs;
   can_run_tracker #(.STUFF_LEN(STUFF_LEN)) u_run (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Clear(bus.i_Frame_Start),
      .i_Count(do_count), .i_Restart(do_restart), .i_Zero(do_zero), .i_Bit(bus.i_Bit),
      .o_Run_Full(run_full), .o_Differs(differs)
   );
   // A frame start clears state before the same-cycle bit is judged.
   assign cur_state = bus.i_Frame_Start ? COUNT : state_q;
   assign cur_nidx = bus.i_Frame_Start ? '0 : nidx_q;
   always_comb begin
      fwd = 1'b0;
      stuff_pulse = 1'b0;
      viol = 1'b0;
      do_count = 1'b0;
      do_restart = 1'b0;
      do_zero = 1'b0;
      state_d = cur_state;
      if (bus.i_Bit_Valid && cur_state != ERROR) begin
         if (!bus.i_Stuff_En) begin
            fwd = 1'b1;
            do_zero = 1'b1;
            state_d = COUNT;
         end else if (cur_state == COUNT) begin
            fwd = 1'b1;
            do_count = 1'b1;
            state_d = run_full ? EXPECT_STUFF : COUNT;
         end else begin
            stuff_pulse = differs;
            do_restart = differs;
            viol = !differs;
            state_d = differs ? COUNT : ERROR;
         end
      end
   end
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q <= COUNT;
         nidx_q <= '0;
         bus.o_Bit_Valid <= 1'b0;
         bus.o_Bit <= 1'b0;
         bus.o_Bit_Index <= '0;
         bus.o_Stuff_Bit <= 1'b0;
         bus.o_Stuff_Error <= 1'b0;
      end else begin
         state_q <= state_d;
         nidx_q <= fwd ? ((cur_nidx == IDX_MAX) ? IDX_MAX : cur_nidx + 1'b1) : cur_nidx;
         bus.o_Bit_Valid <= fwd;
         bus.o_Bit <= fwd ? bus.i_Bit : bus.o_Bit;
         bus.o_Bit_Index <= fwd ? cur_nidx : bus.o_Bit_Index;
         bus.o_Stuff_Bit <= stuff_pulse;
         bus.o_Stuff_Error <= (bus.o_Stuff_Error & ~bus.i_Frame_Start) | viol;
      end
   end
`ifdef CAN_STUFF_CNT_EN
   always_ff @(posedge i_Clock) begin
      if (i_Reset)
         bus.o_Stuff_Count <= '0;
      else
         bus.o_Stuff_Count <= (bus.i_Frame_Start ? 3'd0 : bus.o_Stuff_Count) + {2'b0, stuff_pulse};
   end
`endif
endmodule
